// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the N-entry register file.
//   DEFAULT_WIDTH : default data bits per register
//   DEFAULT_DEPTH : default number of registers
//   addr_width()  : address bits needed to index a file of a given depth
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_word.sv
// -----------------------------------------------------------------------------
// reg_word
// One WIDTH-bit storage word with synchronous clear and load enable.
//   clk  : clock, rising edge
//   clr  : synchronous active-high clear, wins over LOAD
//   LOAD : load enable
//   D    : data in
//   Q    : stored value
// -----------------------------------------------------------------------------
module reg_word
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            Q <= '0;
        end else if (LOAD) begin
            Q <= D;
        end
    end

endmodule : reg_word

// File: rtl/reg_file_n.sv
// -----------------------------------------------------------------------------
// reg_file_n
// DEPTH x WIDTH register file: one write port, two combinational read ports,
// optional hard-wired zero register and optional write-to-read forwarding.
//   clk      : clock, rising edge
//   clr      : synchronous active-high clear of all words and wr_mask
//   LOAD     : write enable
//   waddr    : write address
//   D        : write data
//   raddr_a  : read address, port A
//   raddr_b  : read address, port B
//   Qa, Qb   : read data, ports A and B
//   wr_mask  : bit i set once register i has been written since last clr
// -----------------------------------------------------------------------------
module reg_file_n
    import reg_file_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    localparam int AW     = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             LOAD,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic [DEPTH-1:0] wr_mask
);

    // DEPTH held one bit wider than an address so a power-of-two depth
    // still compares correctly (every address is then in range).
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] load_vec;
    logic             waddr_ok;
    logic             we;

    // A write is effective only outside clr, inside the populated range and
    // not aimed at the hard-wired zero register. Forwarding keys off the
    // same signal so a dropped write is never forwarded.
    always_comb begin
        waddr_ok = ({1'b0, waddr} < DEPTH_W);
        if (ZERO_R0 && (waddr == '0)) begin
            waddr_ok = 1'b0;
        end
        we = LOAD && !clr && waddr_ok;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign load_vec[i] = we && (waddr == AW'(i));

        reg_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk  (clk),
            .clr  (clr),
            .LOAD (load_vec[i]),
            .D    (D),
            .Q    (words[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_mask <= '0;
        end else begin
            wr_mask <= wr_mask | load_vec;
        end
    end

    // Read mux: out-of-range and zero-register addresses read 0; the
    // forwarded write data overrides the stored word when enabled.
    always_comb begin
        Qa = '0;
        if (({1'b0, raddr_a} < DEPTH_W) && !(ZERO_R0 && (raddr_a == '0))) begin
            Qa = words[raddr_a];
        end
        if (BYPASS && we && (raddr_a == waddr)) begin
            Qa = D;
        end
    end

    always_comb begin
        Qb = '0;
        if (({1'b0, raddr_b} < DEPTH_W) && !(ZERO_R0 && (raddr_b == '0))) begin
            Qb = words[raddr_b];
        end
        if (BYPASS && we && (raddr_b == waddr)) begin
            Qb = D;
        end
    end

endmodule : reg_file_n

// File: tb/tb_reg_file_n.sv
// -----------------------------------------------------------------------------
// tb_reg_file_n
// Directed bench for reg_file_n. Three instances share the input stimulus:
//   u_dut : defaults (8 x 16, zero register, forwarding)
//   u_nb  : 8 x 16, no zero register, no forwarding
//   u_d6  : 6 x 16 (non power of two), zero register, forwarding
// -----------------------------------------------------------------------------
module tb_reg_file_n;

    logic        clk;
    logic        clr;
    logic        load;
    logic [2:0]  waddr;
    logic [15:0] d;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;

    logic [15:0] qa, qb, nb_qa, nb_qb, d6_qa, d6_qb;
    logic [7:0]  mask, nb_mask;
    logic [5:0]  d6_mask;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_n u_dut (
        .clk(clk), .clr(clr), .LOAD(load), .waddr(waddr), .D(d),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .Qa(qa), .Qb(qb), .wr_mask(mask)
    );

    reg_file_n #(.ZERO_R0(1'b0), .BYPASS(1'b0)) u_nb (
        .clk(clk), .clr(clr), .LOAD(load), .waddr(waddr), .D(d),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .Qa(nb_qa), .Qb(nb_qb), .wr_mask(nb_mask)
    );

    reg_file_n #(.DEPTH(6)) u_d6 (
        .clk(clk), .clr(clr), .LOAD(load), .waddr(waddr), .D(d),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .Qa(d6_qa), .Qb(d6_qb), .wr_mask(d6_mask)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
        clr = c; load = l; waddr = wa; d = wd; raddr_a = ra; raddr_b = rb;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        tick();

        // reset state
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd5);
        chk("reset_qa",      32'(qa),      32'h0);
        chk("reset_qb",      32'(qb),      32'h0);
        chk("reset_mask",    32'(mask),    32'h0);
        chk("reset_nb_mask", 32'(nb_mask), 32'h0);
        chk("reset_d6_mask", 32'(d6_mask), 32'h0);

        // r3 = 1234, r5 = ABCD
        drive(1'b0, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd5);
        tick();
        drive(1'b0, 1'b1, 3'd5, 16'hABCD, 3'd3, 3'd5);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd5);
        chk("wr35_qa",      32'(qa),      32'h1234);
        chk("wr35_qb",      32'(qb),      32'hABCD);
        chk("wr35_mask",    32'(mask),    32'h28);
        chk("wr35_nb_qb",   32'(nb_qb),   32'hABCD);
        chk("wr35_d6_mask", 32'(d6_mask), 32'h28);

        // both ports on the same register
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5);
        chk("same_qa", 32'(qa), 32'hABCD);
        chk("same_qb", 32'(qb), 32'hABCD);

        // forwarding vs. no forwarding on r2
        drive(1'b0, 1'b1, 3'd2, 16'h5A5A, 3'd2, 3'd3);
        chk("byp_qa_pre",    32'(qa),    32'h5A5A);
        chk("nobyp_qa_pre",  32'(nb_qa), 32'h0000);
        chk("byp_qb_other",  32'(qb),    32'h1234);
        tick();
        drive(1'b0, 1'b0, 3'd2, 16'h5A5A, 3'd2, 3'd3);
        chk("byp_qa_post",   32'(qa),    32'h5A5A);
        chk("nobyp_qa_post", 32'(nb_qa), 32'h5A5A);
        chk("byp_mask",      32'(mask),  32'h2C);

        // write to r0: dropped with the zero register, kept without it
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
        chk("r0_qa_pre", 32'(qa), 32'h0000);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
        chk("r0_qa_post",   32'(qa),      32'h0000);
        chk("r0_mask",      32'(mask),    32'h2C);
        chk("r0_nb_qa",     32'(nb_qa),   32'hFFFF);
        chk("r0_nb_mask",   32'(nb_mask), 32'h2D);
        chk("r0_d6_mask",   32'(d6_mask), 32'h2C);

        // address 6: beyond a 6-deep file, in range for 8-deep
        drive(1'b0, 1'b1, 3'd6, 16'h1111, 3'd6, 3'd6);
        chk("oor_d6_qa_pre", 32'(d6_qa), 32'h0000);
        chk("oor_qa_pre",    32'(qa),    32'h1111);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd6);
        chk("oor_d6_qa",   32'(d6_qa),   32'h0000);
        chk("oor_d6_mask", 32'(d6_mask), 32'h2C);
        chk("oor_qa",      32'(qa),      32'h1111);
        chk("oor_mask",    32'(mask),    32'h6C);

        // walking ones into r1 with LOAD=1, then again with LOAD=0
        for (int x = 0; x < 16; x++) begin
            drive(1'b0, 1'b1, 3'd1, 16'(1 << x), 3'd1, 3'd1);
            tick();
        end
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 3'd1, 3'd1);
        chk("walk_load", 32'(qa), 32'h8000);
        for (int x = 0; x < 16; x++) begin
            drive(1'b0, 1'b0, 3'd1, 16'(1 << x), 3'd1, 3'd1);
            tick();
            chk("walk_hold", 32'(qa), 32'h8000);
        end
        chk("walk_mask", 32'(mask), 32'h6E);

        // full-width pattern, and out-of-range read on the 6-deep file
        drive(1'b0, 1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd7);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd7);
        chk("r7_qa",    32'(qa),    32'hFFFF);
        chk("r7_d6_qb", 32'(d6_qb), 32'h0000);

        // clr with a simultaneous LOAD: no forwarding, clear wins
        drive(1'b1, 1'b1, 3'd4, 16'h7777, 3'd4, 3'd3);
        chk("clr_qa_pre", 32'(qa), 32'h0000);
        chk("clr_qb_pre", 32'(qb), 32'h1234);
        tick();
        chk("clr_qa",      32'(qa),      32'h0000);
        chk("clr_qb",      32'(qb),      32'h0000);
        chk("clr_mask",    32'(mask),    32'h00);
        chk("clr_nb_mask", 32'(nb_mask), 32'h00);
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd1);
        chk("clr_r7", 32'(qa), 32'h0000);
        chk("clr_r1", 32'(qb), 32'h0000);

        // writes resume once clr falls
        drive(1'b0, 1'b1, 3'd4, 16'h7777, 3'd4, 3'd3);
        tick();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd3);
        chk("resume_qa",   32'(qa),   32'h7777);
        chk("resume_qb",   32'(qb),   32'h0000);
        chk("resume_mask", 32'(mask), 32'h10);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file_n

// File: doc/reg_file_n.md
REG_FILE_N -- requirements
Module: reg_file_n

Interface
REQ-001 Parameter WIDTH, default 16, data bits per register.
REQ-002 Parameter DEPTH, default 8, number of registers, legal range 2..64.
REQ-003 Parameter ZERO_R0, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1; when 1, a same-cycle write to a read address is forwarded to that read port.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port clr, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-007 Port LOAD, input, 1, write enable.
REQ-008 Port waddr, input, AW = clog2(DEPTH), write address.
REQ-009 Port D, input, WIDTH, write data.
REQ-010 Port raddr_a, input, AW, read address, port A.
REQ-011 Port raddr_b, input, AW, read address, port B.
REQ-012 Port Qa, output, WIDTH, port A read data.
REQ-013 Port Qb, output, WIDTH, port B read data.
REQ-014 Port wr_mask, output, DEPTH, bit i = 1 once register i has been written since the last clr.

Function
REQ-015 Reads SHALL be combinational: Qa and Qb follow the addressed register with zero-cycle latency.
REQ-016 On a rising edge with LOAD=1 and clr=0, register[waddr] SHALL take D and wr_mask[waddr] SHALL set; all other registers hold.
REQ-017 LOAD=0 SHALL leave every register and wr_mask unchanged.
REQ-018 Forwarding: with BYPASS=1, LOAD=1 and raddr_x==waddr (write not suppressed), Qx SHALL equal D in the same cycle; with BYPASS=0, Qx SHALL show the old value until the edge.
REQ-019 Zero register: with ZERO_R0=1, a write to address 0 SHALL be dropped, Qx SHALL read 0 at address 0, no bypass SHALL occur, and wr_mask[0] SHALL stay 0.
REQ-020 Out of range: when DEPTH is not a power of two, an address >= DEPTH SHALL read 0 and a write to it SHALL be dropped.
REQ-021 Both read ports MAY address the same register, and each SHALL return the identical value.
REQ-022 Data SHALL be stored exactly at WIDTH bits, with no sign or zero extension.

Reset
REQ-023 clr=1 at a rising edge SHALL zero all registers and wr_mask, overriding a simultaneous LOAD.
REQ-024 While clr=1, Qa and Qb SHALL read stored values (zero after the first edge) and SHALL NOT be forwarded from D.
REQ-025 A clr asserted mid-sequence SHALL take effect at that edge; writes resume the cycle after clr falls.

Structure
REQ-026 Shared package reg_file_pkg SHALL hold default WIDTH and DEPTH and the address-width function.
REQ-027 Each storage word SHALL be one instance of sub-module reg_word, a WIDTH-wide register with clk, clr, LOAD, D and Q; reg_file_n adds decode, read mux and bypass.

Verification
REQ-028 clr=1 for one edge after random writes -> all reads are 0x0000 and wr_mask is 0x00.
REQ-029 Write 0x1234 to r3 and 0xABCD to r5, then set raddr_a=3, raddr_b=5 -> Qa=0x1234, Qb=0xABCD, wr_mask=0x28.
REQ-030 With BYPASS=1, LOAD=1, waddr=2, D=0x5A5A, raddr_a=2 -> Qa=0x5A5A before the edge; with BYPASS=0 -> Qa shows the old value, then 0x5A5A after the edge.
REQ-031 With ZERO_R0=1, write 0xFFFF to r0 -> Qa at address 0 is 0x0000 both before and after the edge, and wr_mask[0]=0.
REQ-032 Walking-ones D[x] for x = 0..15 into r1 with LOAD=1, then the same with LOAD=0 -> r1 ends at 0x8000 after the first pass and stays 0x8000 through the second.
REQ-033 clr=1 and LOAD=1 on the same edge (waddr=4, D=0x7777) -> r4 is 0x0000 and wr_mask[4]=0.
